// File: rtl/master_rx_port_pkg.sv
// rtl/master_rx_port_pkg.sv - shared bus instruction codes and receive FSM states
// Contents:
//   INSTR_*     2-bit serial bus instruction codes (INSTR_READ starts a receive burst)
//   rx_state_t  receive port FSM states IDLE / WAIT_HS / RECV
package master_rx_port_pkg;

    localparam logic [1:0] INSTR_NOP   = 2'b00;
    localparam logic [1:0] INSTR_WRITE = 2'b01;
    localparam logic [1:0] INSTR_ADDR  = 2'b10;
    localparam logic [1:0] INSTR_READ  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HS = 2'd1,
        ST_RECV    = 2'd2
    } rx_state_t;

endpackage

// File: rtl/master_rx_port_sync_fifo.sv
// rtl/master_rx_port_sync_fifo.sv - show-ahead synchronous word FIFO with occupancy count
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset (empties FIFO)
//   push, push_data     write one word (ignored when full)
//   pop                 remove head word (ignored when empty)
//   head                current head word, 0 when empty
//   count               words held, 0..DEPTH
module master_rx_port_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    // Data array carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Masked so a stale array entry never shows while the FIFO is empty.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/master_rx_port.sv
// rtl/master_rx_port.sv - master-side serial bus receive port with burst, FIFO and timeout
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   tx_done, instruction  start a burst when instruction is READ and tx_done is high in IDLE
//   burst_num             words in burst minus 1, latched at start
//   rx_data, slave_valid  LANES serial bits per beat, LSB first; slave_valid marks beat 0
//   master_ready          port can accept a word (WAIT_HS and FIFO not full)
//   data_out, data_valid  FIFO head word and non-empty flag
//   data_ack              pops the head when data_valid is high
//   fifo_count            words held in the FIFO
//   rx_done, rx_timeout   one-cycle pulses: burst completed / burst aborted by timeout
module master_rx_port
    import master_rx_port_pkg::*;
#(
    parameter int DATA_LEN  = 8,
    parameter int LANES     = 1,
    parameter int BURST_LEN = 12,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tx_done,
    input  logic [1:0]               instruction,
    input  logic [BURST_LEN-1:0]     burst_num,
    input  logic [LANES-1:0]         rx_data,
    input  logic                     slave_valid,
    output logic                     master_ready,
    output logic [DATA_LEN-1:0]      data_out,
    output logic                     data_valid,
    input  logic                     data_ack,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     rx_done,
    output logic                     rx_timeout
);

    localparam int BEATS = DATA_LEN / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    rx_state_t              state_q;
    rx_state_t              state_d;
    logic [BURST_LEN-1:0]   burst_q;
    logic [BURST_LEN-1:0]   word_cnt;
    logic [BW-1:0]          beat_q;
    logic [TW-1:0]          tmo_q;
    logic [DATA_LEN-1:0]    shift_q;
    logic [DATA_LEN-1:0]    word_next;
    logic [BW-1:0]          beat_sel;

    logic start;
    logic hs;
    logic wait_idle;
    logic tmo_hit;
    logic push;
    logic last_word;

    // Registered-only decode: no combinational path from any input.
    assign master_ready = (state_q == ST_WAIT_HS) && (fifo_count < CW'(DEPTH));

    assign start     = (state_q == ST_IDLE) && tx_done && (instruction == INSTR_READ);
    assign hs        = master_ready && slave_valid;
    assign wait_idle = master_ready && !slave_valid;
    assign tmo_hit   = (TIMEOUT != 0) && wait_idle && (tmo_q == TW'(TIMEOUT - 1));
    assign last_word = (word_cnt == burst_q);

    // A word completes either on the last RECV beat or, for single-beat words,
    // on the handshake itself.
    assign push = ((state_q == ST_RECV) && (beat_q == BW'(BEATS - 1)))
               || (hs && (BEATS == 1));

    // Handshake cycle always carries beat 0; RECV carries the beat counter.
    assign beat_sel = (state_q == ST_RECV) ? beat_q : '0;

    always_comb begin
        word_next = shift_q;
        word_next[int'(beat_sel) * LANES +: LANES] = rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT_HS;
                end
            end
            ST_WAIT_HS: begin
                if (hs) begin
                    if (BEATS == 1) begin
                        state_d = last_word ? ST_IDLE : ST_WAIT_HS;
                    end else begin
                        state_d = ST_RECV;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (push) begin
                    state_d = last_word ? ST_IDLE : ST_WAIT_HS;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_q    <= '0;
            word_cnt   <= '0;
            beat_q     <= '0;
            tmo_q      <= '0;
            shift_q    <= '0;
            rx_done    <= 1'b0;
            rx_timeout <= 1'b0;
        end else begin
            rx_done    <= push && last_word;
            rx_timeout <= tmo_hit;

            if (start) begin
                burst_q  <= burst_num;
                word_cnt <= '0;
            end else if (push && !last_word) begin
                word_cnt <= word_cnt + BURST_LEN'(1);
            end

            if (start) begin
                beat_q <= '0;
            end else if (push) begin
                beat_q <= '0;
            end else if (hs) begin
                beat_q <= BW'(1);
            end else if (state_q == ST_RECV) begin
                beat_q <= beat_q + BW'(1);
            end

            // Only waiting cycles with FIFO space count toward the timeout.
            if (start || hs) begin
                tmo_q <= '0;
            end else if (wait_idle && (TIMEOUT != 0)) begin
                tmo_q <= tmo_q + TW'(1);
            end

            if (hs || (state_q == ST_RECV)) begin
                shift_q <= word_next;
            end
        end
    end

    master_rx_port_sync_fifo #(
        .WIDTH (DATA_LEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (word_next),
        .pop       (data_ack && data_valid),
        .head      (data_out),
        .count     (fifo_count)
    );

    assign data_valid = (fifo_count != '0);

endmodule

// File: tb/tb_master_rx_port.sv
// tb/tb_master_rx_port.sv - self-checking bench for master_rx_port (two configurations)
module tb_master_rx_port;

    logic       clk;
    logic       reset;
    logic       tx_done [2];
    logic [1:0] instr   [2];
    logic [11:0] burst  [2];
    logic [3:0] rxd     [2];
    logic       sv      [2];
    logic       ack     [2];
    logic       mr      [2];
    logic [7:0] dout    [2];
    logic       dv      [2];
    logic       rdone   [2];
    logic       rtmo    [2];
    logic [1:0] fc_a;
    logic [2:0] fc_b;

    logic [7:0] mq [2][$];
    int n_cmp = 0;
    int n_err = 0;

    // Instance 0: 1 lane, 2-deep FIFO, 16-cycle timeout.
    master_rx_port #(.DATA_LEN(8), .LANES(1), .BURST_LEN(12), .DEPTH(2), .TIMEOUT(16)) u_a (
        .clk(clk), .reset(reset), .tx_done(tx_done[0]), .instruction(instr[0]),
        .burst_num(burst[0]), .rx_data(rxd[0][0:0]), .slave_valid(sv[0]),
        .master_ready(mr[0]), .data_out(dout[0]), .data_valid(dv[0]), .data_ack(ack[0]),
        .fifo_count(fc_a), .rx_done(rdone[0]), .rx_timeout(rtmo[0])
    );

    // Instance 1: 4 lanes, 4-deep FIFO, no timeout.
    master_rx_port #(.DATA_LEN(8), .LANES(4), .BURST_LEN(12), .DEPTH(4), .TIMEOUT(0)) u_b (
        .clk(clk), .reset(reset), .tx_done(tx_done[1]), .instruction(instr[1]),
        .burst_num(burst[1]), .rx_data(rxd[1]), .slave_valid(sv[1]),
        .master_ready(mr[1]), .data_out(dout[1]), .data_valid(dv[1]), .data_ack(ack[1]),
        .fifo_count(fc_b), .rx_done(rdone[1]), .rx_timeout(rtmo[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fcnt(input int d);
        return (d == 0) ? int'(fc_a) : int'(fc_b);
    endfunction

    function automatic int lanes(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [7:0] head_exp(input int d);
        return (mq[d].size() != 0) ? mq[d][0] : 8'h00;
    endfunction

    task automatic check_fifo(input string tag, input int d);
        chk({tag, "_count"}, fcnt(d), mq[d].size());
        chk({tag, "_valid"}, dv[d], (mq[d].size() != 0));
        chk({tag, "_head"}, dout[d], head_exp(d));
    endtask

    task automatic start_read(input int d, input logic [1:0] code, input int bn);
        instr[d]   = code;
        tx_done[d] = 1'b1;
        burst[d]   = 12'(bn);
        tick();
        tx_done[d] = 1'b0;
        instr[d]   = 2'b00;
        burst[d]   = 12'($urandom);
    endtask

    task automatic drive_beat(input int d, input logic [7:0] w, input int b);
        logic [7:0] sh;
        sh = w >> (b * lanes(d));
        rxd[d] = (lanes(d) == 1) ? {3'b000, sh[0]} : sh[3:0];
    endtask

    task automatic wait_ready(input int d);
        int waited = 0;
        while (!mr[d] && waited < 200) begin
            tick();
            waited++;
        end
        chk("hs_ready", mr[d], 1'b1);
    endtask

    // Acts as the slave for one word: handshake on beat 0, then one beat per cycle.
    task automatic send_word(input int d, input logic [7:0] w, input bit last, input bit ack_last);
        int nb = 8 / lanes(d);
        wait_ready(d);
        for (int b = 0; b < nb; b++) begin
            drive_beat(d, w, b);
            sv[d] = (b == 0);
            if (b == nb - 1) begin
                chk("pre_push_valid", dv[d], (mq[d].size() != 0));
                if (ack_last) ack[d] = 1'b1;
            end
            tick();
            sv[d] = 1'b0;
            if (b == 0 && nb > 1) chk("recv_ready_low", mr[d], 1'b0);
        end
        ack[d] = 1'b0;
        rxd[d] = 4'($urandom);
        if (ack_last) void'(mq[d].pop_front());
        mq[d].push_back(w);
        check_fifo("push", d);
        chk("rx_done", rdone[d], last);
        chk("rx_timeout_idle", rtmo[d], 1'b0);
    endtask

    task automatic pop_word(input int d);
        chk("pop_valid", dv[d], 1'b1);
        chk("pop_head", dout[d], head_exp(d));
        ack[d] = 1'b1;
        tick();
        ack[d] = 1'b0;
        if (mq[d].size() != 0) void'(mq[d].pop_front());
        check_fifo("pop", d);
    endtask

    task automatic run_burst(input int d, input int n);
        start_read(d, 2'b11, n - 1);
        for (int i = 0; i < n; i++) begin
            send_word(d, 8'($urandom), (i == n - 1), 1'b0);
        end
        tick();
        chk("rx_done_one_pulse", rdone[d], 1'b0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            tx_done[d] = 1'b0; instr[d] = 2'b00; burst[d] = '0;
            rxd[d] = '0; sv[d] = 1'b0; ack[d] = 1'b0;
        end
        reset = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", mr[d], 1'b0);
            chk("rst_done", rdone[d], 1'b0);
            chk("rst_tmo", rtmo[d], 1'b0);
            check_fifo("rst", d);
        end
        reset = 1'b0;
        tick();

        // Single 0xA5 word, one lane, LSB first.
        start_read(0, 2'b11, 0);
        send_word(0, 8'hA5, 1'b1, 1'b0);
        chk("a5_data", dout[0], 8'hA5);
        tick();
        chk("a5_done_pulse", rdone[0], 1'b0);
        pop_word(0);

        // Four-lane burst of three fixed words, two beats each.
        start_read(1, 2'b11, 2);
        send_word(1, 8'h3C, 1'b0, 1'b0);
        send_word(1, 8'h81, 1'b0, 1'b0);
        send_word(1, 8'hFF, 1'b1, 1'b0);
        tick();
        chk("b3_done_pulse", rdone[1], 1'b0);
        for (int i = 0; i < 3; i++) pop_word(1);

        // Back-pressure with a 2-deep FIFO and a 4-word burst.
        start_read(0, 2'b11, 3);
        send_word(0, 8'($urandom), 1'b0, 1'b0);
        send_word(0, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("full_ready_low", mr[0], 1'b0);
        chk("full_count", fcnt(0), 2);
        pop_word(0);
        chk("resume_ready", mr[0], 1'b1);
        send_word(0, 8'($urandom), 1'b0, 1'b0);
        pop_word(0);
        send_word(0, 8'($urandom), 1'b1, 1'b0);
        pop_word(0);

        // Timeout: one word left queued, no slave response.
        start_read(0, 2'b11, 5);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("tmo_early", rtmo[0], 1'b0);
        end
        chk("tmo_ready_wait", mr[0], 1'b1);
        tick();
        chk("tmo_pulse", rtmo[0], 1'b1);
        chk("tmo_idle_ready", mr[0], 1'b0);
        chk("tmo_no_done", rdone[0], 1'b0);
        check_fifo("tmo", 0);
        tick();
        chk("tmo_pulse_end", rtmo[0], 1'b0);
        chk("tmo_stays_idle", mr[0], 1'b0);
        pop_word(0);

        // Reset at beat 4 of word 2.
        begin
            logic [7:0] w2;
            w2 = 8'($urandom);
            start_read(0, 2'b11, 3);
            send_word(0, 8'($urandom), 1'b0, 1'b0);
            wait_ready(0);
            for (int b = 0; b < 4; b++) begin
                drive_beat(0, w2, b);
                sv[0] = (b == 0);
                tick();
                sv[0] = 1'b0;
            end
            drive_beat(0, w2, 4);
            reset = 1'b1;
            tick();
            mq[0].delete();
            mq[1].delete();
            for (int d = 0; d < 2; d++) begin
                chk("mid_rst_ready", mr[d], 1'b0);
                chk("mid_rst_done", rdone[d], 1'b0);
                chk("mid_rst_tmo", rtmo[d], 1'b0);
                check_fifo("mid_rst", d);
            end
            reset = 1'b0;
            tick();
        end
        start_read(0, 2'b11, 0);
        send_word(0, 8'($urandom), 1'b1, 1'b0);
        pop_word(0);

        // Push and pop in the same cycle with one word already queued.
        start_read(1, 2'b11, 1);
        send_word(1, 8'($urandom), 1'b0, 1'b0);
        send_word(1, 8'($urandom), 1'b1, 1'b1);
        chk("pushpop_count", fcnt(1), 1);

        // Non-read instruction must not leave IDLE.
        tick();
        start_read(1, 2'b01, 0);
        chk("nonread_idle", mr[1], 1'b0);
        tick();
        chk("nonread_idle2", mr[1], 1'b0);
        pop_word(1);

        // Random bursts on both configurations.
        for (int it = 0; it < 4; it++) begin
            int n;
            n = $urandom_range(1, 4);
            run_burst(1, n);
            while (mq[1].size() != 0) pop_word(1);
            n = $urandom_range(1, 2);
            run_burst(0, n);
            while (mq[0].size() != 0) pop_word(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
